timer_counter: RTL and testbench

Memory-mapped countdown timer sitting on the device side of the system bridge; the responder for one bridge timer slot (Timer 0 at 0x0000_7F00, Timer 1 at 0x0000_7F10). It exposes three word registers (CTRL, PRESET, COUNT) and raises IRQ to the bridge's hardware-interrupt vector when the count expires. One instance is built per timer slot.

---
 rtl/timer_counter_pkg.sv | 38 +++
 rtl/timer_counter.sv | 128 ++++++++++++
 tb/tb_timer_counter.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_pkg.sv
// timer_counter_pkg: register offsets, CTRL bit layout, mode codes and FSM
// states shared by the timer_counter responder.
package timer_counter_pkg;

  // Word offsets decoded from Addr[3:2]
  localparam logic [1:0] OFF_CTRL   = 2'b00;
  localparam logic [1:0] OFF_PRESET = 2'b01;
  localparam logic [1:0] OFF_COUNT  = 2'b10;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // MODE encodings; 10/11 act as one-shot
  localparam logic [1:0] MODE_ONESHOT    = 2'b00;
  localparam logic [1:0] MODE_AUTORELOAD = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_CNT  = 2'b10,
    ST_INT  = 2'b11
  } tc_state_e;

  // Assemble the CTRL read-back word; unused high bits read 0
  function automatic logic [31:0] ctrl_word(input logic en, input logic [1:0] mode,
                                            input logic im);
    logic [31:0] w;
    w = 32'd0;
    w[CTRL_EN] = en;
    w[CTRL_MODE_HI:CTRL_MODE_LO] = mode;
    w[CTRL_IM] = im;
    return w;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped countdown timer (CTRL / PRESET / COUNT) that
// raises a level IRQ on expiry. Build option: define TIMER_AUTORELOAD_EN to
// make MODE 01 reload and restart automatically; without it every mode is
// one-shot and the MODE field is not stored.
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  tc_state_e   state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic        irq_flag_q, irq_flag_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;

  logic [1:0]  offs;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        auto_reload;
  logic        unused_addr;

  assign offs        = Addr[3:2];
  assign ctrl_wr     = WE && (offs == OFF_CTRL);
  assign preset_wr   = WE && (offs == OFF_PRESET);
  // The bridge has already range-qualified the access
  assign unused_addr = ^Addr[31:4];

`ifdef TIMER_AUTORELOAD_EN
  assign auto_reload = (mode_q == MODE_AUTORELOAD);
`else
  assign auto_reload = 1'b0;
`endif

  // Next-state: FSM sequencing first, then bus writes which take precedence
  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    mode_d     = mode_q;
    im_d       = im_q;
    irq_flag_d = irq_flag_q;
    preset_d   = preset_q;
    count_d    = count_q;

    case (state_q)
      ST_IDLE: begin
        if (en_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d    = 32'd0;
          irq_flag_d = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        state_d = ST_IDLE;
        if (auto_reload) irq_flag_d = 1'b0;
        else             en_d       = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (preset_wr) preset_d = Din;

    // A CTRL write wins over both the expiry flag set and the one-shot EN clear
    if (ctrl_wr) begin
      en_d       = Din[CTRL_EN];
      im_d       = Din[CTRL_IM];
      irq_flag_d = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      mode_d     = Din[CTRL_MODE_HI:CTRL_MODE_LO];
`else
      mode_d     = MODE_ONESHOT;
`endif
    end
  end

  // State and register file update with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      mode_q     <= MODE_ONESHOT;
      im_q       <= 1'b0;
      irq_flag_q <= 1'b0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      im_q       <= im_d;
      irq_flag_q <= irq_flag_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
    end
  end

  // Zero-latency read mux; the reserved offset reads 0
  always_comb begin
    case (offs)
      OFF_CTRL:   Dout = ctrl_word(en_q, mode_q, im_q);
      OFF_PRESET: Dout = preset_q;
      OFF_COUNT:  Dout = count_q;
      default:    Dout = 32'd0;
    endcase
  end

  assign IRQ = irq_flag_q & im_q;

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: table-driven vectors, hand-written corner sequences and a
// randomized run against an elapsed-time reference model of timer_counter.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_PRE  = 2'd1;
  localparam logic [1:0] A_CNT  = 2'd2;
  localparam logic [1:0] A_RSV  = 2'd3;

  timer_counter dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  vec_t vt[$];

  // Reference model: registers plus run progress measured in edges since start
  logic        m_en, m_im, m_flag;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_count, m_p;
  bit          m_run;
  int unsigned m_k;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_bus(input logic we, input logic [1:0] a, input logic [31:0] d);
    WE   = we;
    Addr = {28'd0, a};
    Din  = d;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    set_bus(1'b1, a, d);
    @(posedge clk);
    #1;
    set_bus(1'b0, a, 32'd0);
  endtask

  task automatic wait_dout(input string name, input logic [1:0] a, input logic [31:0] v,
                           input int bound);
    bit hit;
    hit = 0;
    set_bus(1'b0, a, 32'd0);
    for (int n = 0; n < bound && !hit; n++) begin
      @(negedge clk);
      if (Dout == v) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: timeout, last read 0x%08h, waited for 0x%08h", name, Dout, v);
    end
  endtask

  function automatic bit m_auto();
`ifdef TIMER_AUTORELOAD_EN
    return (m_mode == 2'b01);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_dout(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_im = 0; m_flag = 0; m_mode = 2'd0;
    m_preset = 0; m_count = 0; m_p = 0; m_run = 0; m_k = 0;
  endtask

  // One edge: start one edge after EN seen idle, load P the edge after, then
  // count(k) = max(P-k,0) for k=1..max(P,1) with expiry at the last, then finish
  task automatic model_step(input logic we, input logic [1:0] a, input logic [31:0] d);
    logic        n_en, n_flag;
    logic [31:0] n_count, n_p;
    bit          n_run;
    int unsigned n_k, lim;
    n_en = m_en; n_flag = m_flag; n_count = m_count; n_p = m_p;
    n_run = m_run; n_k = m_k;
    lim = (m_p > 32'd1) ? m_p : 32'd1;
    if (!m_run) begin
      if (m_en) begin n_run = 1; n_k = 0; end
    end else if (m_k == 0) begin
      n_count = m_preset; n_p = m_preset; n_k = 1;
    end else if (m_k <= lim) begin
      if (!m_en) n_run = 0;
      else begin
        n_count = (m_p > m_k) ? m_p - m_k : 32'd0;
        if (m_k == lim) n_flag = 1;
        n_k = m_k + 1;
      end
    end else begin
      n_run = 0;
      if (m_auto()) n_flag = 0;
      else          n_en = 0;
    end
    if (we && a == A_PRE) m_preset = d;
    if (we && a == A_CTRL) begin
      n_en = d[0];
      m_im = d[3];
      n_flag = 0;
`ifdef TIMER_AUTORELOAD_EN
      m_mode = d[2:1];
`else
      m_mode = 2'd0;
`endif
    end
    m_en = n_en; m_flag = n_flag; m_count = n_count; m_p = n_p;
    m_run = n_run; m_k = n_k;
  endtask

  initial begin
    logic [1:0]  ra;
    logic [31:0] rd;
    logic        rwe;
    int          r;

    reset = 1'b1;
    set_bus(1'b0, A_CTRL, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Table: reset readback, one-shot PRESET=5, clear, ignored writes
    vt.push_back('{1'b0, A_CTRL, 32'h0, 32'h0, 1'b0});
    vt.push_back('{1'b0, A_PRE,  32'h0, 32'h0, 1'b0});
    vt.push_back('{1'b0, A_CNT,  32'h0, 32'h0, 1'b0});
    vt.push_back('{1'b0, A_RSV,  32'h0, 32'h0, 1'b0});
    vt.push_back('{1'b1, A_PRE,  32'h5, 32'h0, 1'b0});
    vt.push_back('{1'b1, A_CTRL, 32'h9, 32'h0, 1'b0});
    vt.push_back('{1'b0, A_CTRL, 32'h0, 32'h9, 1'b0});
    vt.push_back('{1'b0, A_CNT,  32'h0, 32'h0, 1'b0});
    vt.push_back('{1'b0, A_CNT,  32'h0, 32'h5, 1'b0});
    vt.push_back('{1'b0, A_CNT,  32'h0, 32'h4, 1'b0});
    vt.push_back('{1'b0, A_CNT,  32'h0, 32'h3, 1'b0});
    vt.push_back('{1'b0, A_CNT,  32'h0, 32'h2, 1'b0});
    vt.push_back('{1'b0, A_CNT,  32'h0, 32'h1, 1'b0});
    vt.push_back('{1'b0, A_CNT,  32'h0, 32'h0, 1'b1});
    vt.push_back('{1'b0, A_CTRL, 32'h0, 32'h8, 1'b1});
    vt.push_back('{1'b0, A_PRE,  32'h0, 32'h5, 1'b1});
    vt.push_back('{1'b1, A_CTRL, 32'h0, 32'h8, 1'b1});
    vt.push_back('{1'b0, A_CTRL, 32'h0, 32'h0, 1'b0});
    vt.push_back('{1'b1, A_CNT,  32'hFFFF, 32'h0, 1'b0});
    vt.push_back('{1'b0, A_CNT,  32'h0, 32'h0, 1'b0});
    vt.push_back('{1'b1, A_RSV,  32'hFFFF_FFFF, 32'h0, 1'b0});
    vt.push_back('{1'b0, A_RSV,  32'h0, 32'h0, 1'b0});
    vt.push_back('{1'b0, A_PRE,  32'h0, 32'h5, 1'b0});

    for (int i = 0; i < vt.size(); i++) begin
      set_bus(vt[i].we, vt[i].a, vt[i].d);
      @(negedge clk);
      chk($sformatf("vec%0d dout", i), Dout, vt[i].exp_dout);
      chk($sformatf("vec%0d irq", i), {31'd0, IRQ}, {31'd0, vt[i].exp_irq});
      @(posedge clk);
      #1;
    end
    set_bus(1'b0, A_CTRL, 32'd0);

    // MODE 01: periodic pulses with reload, or plain one-shot without the option
    wr(A_PRE, 32'd4);
    wr(A_CTRL, 32'hB);
    set_bus(1'b0, A_CTRL, 32'd0);
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
`ifdef TIMER_AUTORELOAD_EN
      chk($sformatf("auto irq t%0d", i), {31'd0, IRQ},
          {31'd0, (i >= 6) && ((i - 6) % 7 == 0)});
      chk($sformatf("auto ctrl t%0d", i), Dout, 32'hB);
`else
      chk($sformatf("mode1 irq t%0d", i), {31'd0, IRQ}, {31'd0, i >= 6});
      chk($sformatf("mode1 ctrl t%0d", i), Dout, (i < 7) ? 32'h9 : 32'h8);
`endif
    end
    wr(A_CTRL, 32'h0);

    // Masked expiry, then stop mid-count
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'h1);
    wait_dout("mask en clear", A_CTRL, 32'h0, 20);
    chk("mask irq", {31'd0, IRQ}, 32'd0);
    set_bus(1'b0, A_CNT, 32'd0);
    #1;
    chk("mask count", Dout, 32'd0);
    wr(A_CTRL, 32'h1);
    wait_dout("stop see 3", A_CNT, 32'd3, 10);
    set_bus(1'b1, A_CTRL, 32'h8);
    @(posedge clk);
    #1;
    set_bus(1'b0, A_CNT, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("stop count t%0d", i), Dout, 32'd2);
      chk($sformatf("stop irq t%0d", i), {31'd0, IRQ}, 32'd0);
    end
    set_bus(1'b0, A_CTRL, 32'd0);
    #1;
    chk("stop ctrl", Dout, 32'h8);

    // PRESET=0 expires three edges after the CTRL write
    wr(A_PRE, 32'd0);
    wr(A_CTRL, 32'h9);
    set_bus(1'b0, A_CNT, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("p0 irq t%0d", i), {31'd0, IRQ}, {31'd0, i >= 3});
      chk($sformatf("p0 count t%0d", i), Dout, (i < 2) ? 32'd2 : 32'd0);
    end
    wr(A_CTRL, 32'h0);

    // PRESET rewritten mid-count: current run unaffected, next run uses it
    wr(A_PRE, 32'd6);
    wr(A_CTRL, 32'h1);
    wait_dout("midpre see 5", A_CNT, 32'd5, 10);
    set_bus(1'b1, A_PRE, 32'd2);
    @(posedge clk);
    #1;
    set_bus(1'b0, A_CNT, 32'd0);
    @(negedge clk);
    chk("midpre count a", Dout, 32'd4);
    @(negedge clk);
    chk("midpre count b", Dout, 32'd3);
    set_bus(1'b0, A_PRE, 32'd0);
    #1;
    chk("midpre preset", Dout, 32'd2);
    wait_dout("midpre done", A_CTRL, 32'h0, 20);
    wr(A_CTRL, 32'h9);
    set_bus(1'b0, A_CNT, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("rerun count t%0d", i), Dout,
          (i == 2) ? 32'd2 : (i == 3) ? 32'd1 : 32'd0);
      chk($sformatf("rerun irq t%0d", i), {31'd0, IRQ}, {31'd0, i >= 4});
    end
    wr(A_CTRL, 32'h0);

    // CTRL write landing in the INT cycle: flag cleared, EN kept, new run
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'h9);
    set_bus(1'b0, A_CTRL, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("sim irq t%0d", i), {31'd0, IRQ}, {31'd0, i == 5});
    end
    set_bus(1'b1, A_CTRL, 32'h9);
    @(posedge clk);
    #1;
    set_bus(1'b0, A_CTRL, 32'd0);
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      chk($sformatf("sim2 irq t%0d", j), {31'd0, IRQ}, {31'd0, j >= 5});
      chk($sformatf("sim2 ctrl t%0d", j), Dout, (j < 6) ? 32'h9 : 32'h8);
    end
    wr(A_CTRL, 32'h0);

    // Asynchronous reset in the middle of a count
    wr(A_PRE, 32'd5);
    wr(A_CTRL, 32'h9);
    set_bus(1'b0, A_CNT, 32'd0);
    repeat (3) @(negedge clk);
    chk("pre-reset count", Dout, 32'd5);
    reset = 1'b1;
    #1;
    chk("reset irq", {31'd0, IRQ}, 32'd0);
    chk("reset count", Dout, 32'd0);
    set_bus(1'b0, A_CTRL, 32'd0);
    #1;
    chk("reset ctrl", Dout, 32'd0);
    set_bus(1'b0, A_PRE, 32'd0);
    #1;
    chk("reset preset", Dout, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    model_step(1'b0, A_PRE, 32'd0);
    #1;

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      r   = $urandom_range(0, 9);
      ra  = 2'($urandom_range(0, 3));
      rd  = $urandom;
      rwe = 1'b0;
      if (r < 2) begin
        rwe = 1'b1; ra = A_CTRL;
        rd[0] = ($urandom_range(0, 3) != 0);
      end else if (r < 4) begin
        rwe = 1'b1; ra = A_PRE;
        rd = $urandom_range(0, 6);
      end else if (r == 4) begin
        rwe = 1'b1;
        ra = ($urandom_range(0, 1) != 0) ? A_CNT : A_RSV;
      end
      set_bus(rwe, ra, rd);
      @(negedge clk);
      chk($sformatf("rnd%0d dout", n), Dout, exp_dout(ra));
      chk($sformatf("rnd%0d irq", n), {31'd0, IRQ}, {31'd0, m_flag & m_im});
      @(posedge clk);
      model_step(rwe, ra, rd);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
